// File: rtl/reset_sequencer_pkg.sv
// ============================================================================
// Module      : reset_sequencer_pkg
// Description : Shared types and helpers for the staged reset sequencer.
//               Contains the sequencer state encoding and the function that
//               sizes the shared settle/timeout counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package reset_sequencer_pkg;

  // Sequencer states, 2-bit encoding.
  typedef enum logic [1:0] {
    ST_DELAY      = 2'd0,
    ST_WAIT_READY = 2'd1,
    ST_DONE       = 2'd2,
    ST_ERROR      = 2'd3
  } seq_state_e;

  // Width needed to hold every value 0..max(a,b); never less than one bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return ($clog2(m + 1) < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/reset_sequencer_counter.sv
// ============================================================================
// Module      : cycle_counter
// Description : Clearable, enabled up-counter with a terminal-value compare.
//               The count is registered; term_o flags count == term_i.
// Ports       : clk_i    - clock
//               rst_i    - synchronous active-high reset (count -> 0)
//               clear_i  - synchronous clear, wins over enable_i
//               enable_i - increment by one this cycle
//               term_i   - terminal value to compare against
//               count_o  - registered count
//               term_o   - high while count_o equals term_i
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cycle_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [WIDTH-1:0] term_i,
  output logic [WIDTH-1:0] count_o,
  output logic             term_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign term_o  = (count_q == term_i);

endmodule

`default_nettype wire

// File: rtl/reset_sequencer.sv
// ============================================================================
// Module      : reset_sequencer
// Description : Staged reset-release controller. After rst_i drops, releases
//               STAGES downstream reset domains in order, each after a
//               DELAY_CYCLES settle period and gated on the previous domain's
//               ready. Optional ready timeout drives a sticky error.
// Macro       : RESET_SEQUENCER_TIMEOUT_EN - when defined, a stage that does
//               not report ready within TIMEOUT_CYCLES of its release sends
//               the sequencer to ERROR (all resets re-asserted, error_o=1).
//               When undefined, WAIT_READY waits forever and error_o is 0.
// Ports       : clk_i      - clock
//               rst_i      - synchronous active-high reset
//               soft_rst_i - synchronous request to restart the sequence
//               ready_i    - per-stage init-done, bit k pairs with rst_o[k]
//               rst_o      - per-stage active-high reset (registered)
//               stage_o    - current / failing stage index
//               done_o     - all stages released and ready
//               error_o    - sticky ready-timeout flag
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int STAGES         = 4,
  parameter int DELAY_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    soft_rst_i,
  input  logic [STAGES-1:0]                       ready_i,
  output logic [STAGES-1:0]                       rst_o,
  output logic [(STAGES > 1 ? $clog2(STAGES) : 1)-1:0] stage_o,
  output logic                                    done_o,
  output logic                                    error_o
);

  localparam int SW = (STAGES > 1) ? $clog2(STAGES) : 1;
`ifdef RESET_SEQUENCER_TIMEOUT_EN
  localparam int CW = cnt_width(DELAY_CYCLES, TIMEOUT_CYCLES);
`else
  localparam int CW = cnt_width(DELAY_CYCLES, 1);
  // Timeout length has no effect in this build.
  localparam int timeout_unused = TIMEOUT_CYCLES;
`endif

  seq_state_e        state_q, state_d;
  logic [SW-1:0]     stage_q, stage_d;
  logic [STAGES-1:0] rst_q,   rst_d;
  logic              done_q,  done_d;
  logic              err_q,   err_d;

  logic              cnt_clr;
  logic              cnt_en;
  logic [CW-1:0]     cnt_term;
  logic              cnt_hit;
  logic [CW-1:0]     cnt_q_unused;

  // One counter serves both the settle delay and the ready timeout; it is
  // cleared on every state transition so it can never wrap.
  cycle_counter #(
    .WIDTH (CW)
  ) u_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (cnt_clr),
    .enable_i (cnt_en),
    .term_i   (cnt_term),
    .count_o  (cnt_q_unused),
    .term_o   (cnt_hit)
  );

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_DELAY;
      stage_q <= '0;
      rst_q   <= '1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    stage_d  = stage_q;
    rst_d    = rst_q;
    done_d   = done_q;
    err_d    = err_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    cnt_term = CW'(DELAY_CYCLES - 1);

    if (soft_rst_i) begin
      state_d = ST_DELAY;
      stage_d = '0;
      rst_d   = '1;
      done_d  = 1'b0;
      err_d   = 1'b0;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        ST_DELAY: begin
          cnt_en = 1'b1;
          if (cnt_hit) begin
            rst_d[stage_q] = 1'b0;
            cnt_clr        = 1'b1;
            state_d        = ST_WAIT_READY;
          end
        end

        ST_WAIT_READY: begin
`ifdef RESET_SEQUENCER_TIMEOUT_EN
          cnt_term = CW'(TIMEOUT_CYCLES - 1);
`endif
          // Ready is checked first so it wins over a same-edge timeout.
          if (ready_i[stage_q]) begin
            cnt_clr = 1'b1;
            if (stage_q == SW'(STAGES - 1)) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              stage_d = stage_q + SW'(1);
              state_d = ST_DELAY;
            end
`ifdef RESET_SEQUENCER_TIMEOUT_EN
          end else if (cnt_hit) begin
            state_d = ST_ERROR;
            rst_d   = '1;
            err_d   = 1'b1;
            cnt_clr = 1'b1;
          end else begin
            cnt_en = 1'b1;
`endif
          end
        end

        // DONE and ERROR hold until a reset of either kind.
        ST_DONE:  ;
        ST_ERROR: ;
        default:  state_d = ST_DELAY;
      endcase
    end
  end

  // Output logic; err_q can only be set with the timeout compiled in.
  always_comb begin
    rst_o   = rst_q;
    stage_o = stage_q;
    done_o  = done_q;
    error_o = err_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_reset_sequencer.sv
// ============================================================================
// Module      : tb_reset_sequencer
// Description : Self-checking bench for reset_sequencer (STAGES=3,
//               DELAY_CYCLES=4, TIMEOUT_CYCLES=8). Directed timing scenarios
//               plus randomized ready/soft-reset/reset traffic compared each
//               cycle against a timing-rule reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_reset_sequencer;

  localparam int S = 3;
  localparam int D = 4;
  localparam int T = 8;
`ifdef RESET_SEQUENCER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         soft_rst_i = 1'b0;
  logic [S-1:0] ready_i = '0;
  logic [S-1:0] rst_o;
  logic [1:0]   stage_o;
  logic         done_o;
  logic         error_o;

  always #5 clk_i = ~clk_i;

  reset_sequencer #(
    .STAGES         (S),
    .DELAY_CYCLES   (D),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .soft_rst_i (soft_rst_i),
    .ready_i    (ready_i),
    .rst_o      (rst_o),
    .stage_o    (stage_o),
    .done_o     (done_o),
    .error_o    (error_o)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: how many stages are released, which stage is current,
  // and how many cycles have elapsed in the current delay or wait period.
  int m_rel   = 0;
  int m_since = 0;
  int m_stg   = 0;
  bit m_done  = 1'b0;
  bit m_err   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic s, input logic [S-1:0] rdy);
    if (r || s) begin
      m_rel = 0; m_since = 0; m_stg = 0; m_done = 1'b0; m_err = 1'b0;
    end else if (m_done || m_err) begin
      // terminal
    end else if (m_rel == m_stg) begin
      m_since++;
      if (m_since == D) begin
        m_rel++;
        m_since = 0;
      end
    end else if (rdy[m_stg]) begin
      if (m_stg == S - 1) m_done = 1'b1;
      else begin
        m_stg++;
        m_since = 0;
      end
    end else begin
      m_since++;
      if (TO_EN && m_since == T) m_err = 1'b1;
    end
  endtask

  function automatic logic [S-1:0] exp_rst();
    int mask;
    if (m_err) return '1;
    mask = (1 << m_rel) - 1;
    return S'(~mask);
  endfunction

  task automatic step(input logic r, input logic s, input logic [S-1:0] rdy);
    @(negedge clk_i);
    rst_i = r; soft_rst_i = s; ready_i = rdy;
    @(posedge clk_i);
    model_step(r, s, rdy);
    #1;
    chk("rst_o",   32'(rst_o),   32'(exp_rst()));
    chk("stage_o", 32'(stage_o), 32'(m_stg));
    chk("done_o",  32'(done_o),  32'(m_done));
    chk("error_o", 32'(error_o), 32'(m_err));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rst_o"},   32'(rst_o),   32'h7);
    chk({tag, "_stage_o"}, 32'(stage_o), 32'h0);
    chk({tag, "_done_o"},  32'(done_o),  32'h0);
    chk({tag, "_error_o"}, 32'(error_o), 32'h0);
  endtask

  initial begin
    int f0, f1, f2, fd, fe, kr;
    logic [S-1:0] rdy;
    int thr;

    // Reset state
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    chk_reset_vals("reset");

    // Nominal, all ready
    f0 = -1; f1 = -1; f2 = -1; fd = -1;
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, 1'b0, 3'b111);
      if (f0 < 0 && !rst_o[0]) f0 = k;
      if (f1 < 0 && !rst_o[1]) f1 = k;
      if (f2 < 0 && !rst_o[2]) f2 = k;
      if (fd < 0 && done_o)    fd = k;
    end
    chk("nom_rst0_edge", 32'(f0), 32'd4);
    chk("nom_rst1_edge", 32'(f1), 32'd9);
    chk("nom_rst2_edge", 32'(f2), 32'd14);
    chk("nom_done_edge", 32'(fd), 32'd15);
    chk("nom_error",     32'(error_o), 32'd0);

`ifdef RESET_SEQUENCER_TIMEOUT_EN
    // Stage 1 never ready: timeout 8 cycles after its release
    step(1'b1, 1'b0, '0);
    f1 = -1; fe = -1;
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, 1'b0, 3'b101);
      if (f1 < 0 && !rst_o[1]) f1 = k;
      if (fe < 0 && error_o)   fe = k;
    end
    chk("to_rst1_edge",  32'(f1), 32'd9);
    chk("to_error_edge", 32'(fe), 32'd17);
    for (int k = 0; k < 50; k++) step(1'b0, 1'b0, 3'b111);
    chk("to_hold_rst_o", 32'(rst_o),   32'h7);
    chk("to_hold_stage", 32'(stage_o), 32'd1);
    chk("to_hold_error", 32'(error_o), 32'd1);
    // rst_i after the error clears everything
    step(1'b1, 1'b0, '0);
    chk_reset_vals("rst_after_err");
`else
    // No timeout: ready_i[0] withheld for 100 cycles
    step(1'b1, 1'b0, '0);
    kr = 105;
    f1 = -1;
    for (int k = 1; k < kr; k++) step(1'b0, 1'b0, '0);
    chk("wait_error",  32'(error_o), 32'd0);
    chk("wait_rst_o",  32'(rst_o),   32'h6);
    for (int k = kr; k <= kr + 10; k++) begin
      step(1'b0, 1'b0, 3'b111);
      if (f1 < 0 && !rst_o[1]) f1 = k;
    end
    chk("wait_rst1_edge", 32'(f1), 32'(kr + 4));
`endif

    // Ready[0] first high on the edge where the timeout would fire
    step(1'b1, 1'b0, '0);
    for (int k = 1; k <= 12; k++) begin
      step(1'b0, 1'b0, (k >= 12) ? 3'b001 : 3'b000);
    end
    chk("race_stage", 32'(stage_o), 32'd1);
    chk("race_error", 32'(error_o), 32'd0);

    // soft_rst_i during stage-2 DELAY
    step(1'b1, 1'b0, '0);
    for (int k = 1; k <= 11; k++) step(1'b0, 1'b0, 3'b111);
    step(1'b0, 1'b1, 3'b111);
    chk_reset_vals("soft");
    f0 = -1; fd = -1;
    for (int k = 1; k <= 16; k++) begin
      step(1'b0, 1'b0, 3'b111);
      if (f0 < 0 && !rst_o[0]) f0 = k;
      if (fd < 0 && done_o)    fd = k;
    end
    chk("soft_rst0_edge", 32'(f0), 32'd4);
    chk("soft_done_edge", 32'(fd), 32'd15);

    // rst_i pulse while waiting on stage 1
    step(1'b1, 1'b0, '0);
    for (int k = 1; k <= 11; k++) step(1'b0, 1'b0, 3'b001);
    chk("w1_stage", 32'(stage_o), 32'd1);
    step(1'b1, 1'b0, 3'b001);
    chk_reset_vals("w1_rst");

    // Randomized traffic against the model
    thr = 1;
    for (int k = 0; k < 3000; k++) begin
      if (k % 256 == 0) thr = $urandom_range(0, 3);
      rdy = '0;
      for (int b = 0; b < S; b++) rdy[b] = ($urandom_range(0, 3) < thr);
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 149) == 0), rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
